// File: rtl/gt_mem_pkg.sv
// ---------------------------------------------------------------------------
// gt_mem_pkg
//   Shared types and helpers for the line-fill controller and its write
//   buffer.
//   - DEF_LINE_BYTES / LINE_BITS / OFFSET_W : line geometry (32-byte lines).
//   - state_e   : controller FSM states.
//   - line_align: clear the byte-offset bits of an address.
//   - byte_sel  : pick one byte out of a line by byte offset.
// ---------------------------------------------------------------------------
package gt_mem_pkg;

    localparam int unsigned DEF_LINE_BYTES = 32;
    localparam int unsigned LINE_BITS      = DEF_LINE_BYTES * 8;
    localparam int unsigned OFFSET_W       = $clog2(DEF_LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        RD_ISSUE,
        RD_WAIT,
        FILL,
        WB
    } state_e;

    // Works on a 64-bit container so callers of any address width up to 64
    // can share it; off_w is the number of low bits to clear.
    function automatic logic [63:0] line_align(input logic [63:0] addr,
                                               input int unsigned off_w);
        logic [63:0] mask;
        mask = (64'd1 << off_w) - 64'd1;
        return addr & ~mask;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [LINE_BITS-1:0] line,
                                            input logic [OFFSET_W-1:0]  off);
        return line[8*off +: 8];
    endfunction

endpackage

// File: rtl/gt_wb_buffer.sv
// ---------------------------------------------------------------------------
// gt_wb_buffer
//   One-entry write buffer holding an evicted line until it is drained.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset (valid only)
//     load            : capture load_addr (line-aligned) and load_data
//     load_addr/data  : incoming evicted line
//     clr             : invalidate the entry (line has been written out)
//     cmp_addr        : byte address to compare against the held line
//     valid           : entry holds a line
//     line_addr, data : held line address and contents
//     hit             : valid and cmp_addr falls in the held line
// ---------------------------------------------------------------------------
module gt_wb_buffer
    import gt_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OFF_W  = OFFSET_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [LINE_BITS-1:0] load_data,
    input  logic                 clr,
    input  logic [ADDR_W-1:0]    cmp_addr,
    output logic                 valid,
    output logic [ADDR_W-1:0]    line_addr,
    output logic [LINE_BITS-1:0] data,
    output logic                 hit
);

    logic                 valid_q, valid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LINE_BITS-1:0] data_q, data_d;
    logic [ADDR_W-1:0]    cmp_line;

    assign cmp_line = ADDR_W'(line_align(64'(cmp_addr), OFF_W));

    // load and clr never coincide: loads are only accepted while empty,
    // clears only happen while full.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = ADDR_W'(line_align(64'(load_addr), OFF_W));
            data_d  = load_data;
        end else if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Contents are meaningless while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign valid     = valid_q;
    assign line_addr = addr_q;
    assign data      = data_q;
    assign hit       = valid_q && (addr_q == cmp_line);

endmodule

// File: rtl/gt_line_fill_ctrl.sv
// ---------------------------------------------------------------------------
// gt_line_fill_ctrl
//   Miss/fill controller between the cache and main memory. Handles one
//   outstanding read miss with a fixed-latency line read, forwards from a
//   one-entry victim write buffer on a same-line miss, and drains the buffer
//   to memory when no miss is pending.
//   Ports:
//     CLK, CLEAR              : clock, synchronous active-high reset
//     miss_req/addr/ready     : miss handshake from the cache
//     wb_valid/addr/data/ready: evicted-line handshake from the cache
//     mem_rd, mem_wr          : one-cycle memory strobes (never together)
//     mem_addr, mem_wdata     : line address / write data for the strobes
//     mem_rdata               : read data, valid MEM_LATENCY cycles after mem_rd
//     fill_valid              : one-cycle fill pulse
//     fill_addr/line/byte     : fill result, held between fills
//     busy                    : FSM not idle or write buffer occupied
// ---------------------------------------------------------------------------
module gt_line_fill_ctrl
    import gt_mem_pkg::*;
#(
    parameter int unsigned LINE_BYTES  = DEF_LINE_BYTES,
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                 CLK,
    input  logic                 CLEAR,
    input  logic                 miss_req,
    input  logic [ADDR_W-1:0]    miss_addr,
    output logic                 miss_ready,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic [LINE_BITS-1:0] wb_data,
    output logic                 wb_ready,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    output logic                 fill_valid,
    output logic [ADDR_W-1:0]    fill_addr,
    output logic [LINE_BITS-1:0] fill_line,
    output logic [7:0]           fill_byte,
    output logic                 busy
);

    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return ADDR_W'(line_align(64'(a), OFF_W));
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic [ADDR_W-1:0]    fill_addr_q, fill_addr_d;
    logic [LINE_BITS-1:0] fill_line_q, fill_line_d;
    logic [7:0]           fill_byte_q, fill_byte_d;

    logic                 wbuf_valid, wbuf_hit, wbuf_clr;
    logic [ADDR_W-1:0]    wbuf_addr;
    logic [LINE_BITS-1:0] wbuf_data;

    logic                 miss_acc, wb_acc, same_new;
    logic [ADDR_W-1:0]    miss_line;
    logic [LINE_BITS-1:0] fwd_line;

    assign miss_acc  = miss_req && (state_q == IDLE);
    assign wb_acc    = wb_valid && !wbuf_valid;
    assign miss_line = align(miss_addr);
    // A line arriving in the same cycle as the miss can be forwarded directly.
    assign same_new  = wb_acc && (align(wb_addr) == miss_line);
    assign fwd_line  = wbuf_hit ? wbuf_data : wb_data;

    gt_wb_buffer #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_wbuf (
        .clk       (CLK),
        .rst       (CLEAR),
        .load      (wb_acc),
        .load_addr (wb_addr),
        .load_data (wb_data),
        .clr       (wbuf_clr),
        .cmp_addr  (miss_addr),
        .valid     (wbuf_valid),
        .line_addr (wbuf_addr),
        .data      (wbuf_data),
        .hit       (wbuf_hit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        fill_addr_d = fill_addr_q;
        fill_line_d = fill_line_q;
        fill_byte_d = fill_byte_q;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_valid  = 1'b0;
        wbuf_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                // A miss always wins over draining the buffer.
                if (miss_acc) begin
                    req_addr_d = miss_addr;
                    if (wbuf_hit || same_new) begin
                        // Fill registers load now so they are valid in FWD.
                        fill_addr_d = miss_line;
                        fill_line_d = fwd_line;
                        fill_byte_d = byte_sel(fwd_line, OFFSET_W'(miss_addr[OFF_W-1:0]));
                        state_d     = FWD;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end else if (wbuf_valid) begin
                    state_d = WB;
                end
            end
            FWD: begin
                fill_valid = 1'b1;
                state_d    = IDLE;
            end
            RD_ISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = align(req_addr_q);
                cnt_d    = CNT_W'(MEM_LATENCY);
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last wait cycle: mem_rdata is valid now.
                if (cnt_q == CNT_W'(1)) begin
                    fill_addr_d = align(req_addr_q);
                    fill_line_d = mem_rdata;
                    fill_byte_d = byte_sel(mem_rdata, OFFSET_W'(req_addr_q[OFF_W-1:0]));
                    state_d     = FILL;
                end
            end
            FILL: begin
                fill_valid = 1'b1;
                state_d    = IDLE;
            end
            WB: begin
                mem_wr    = 1'b1;
                mem_addr  = wbuf_addr;
                mem_wdata = wbuf_data;
                wbuf_clr  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_addr_q <= '0;
            fill_line_q <= '0;
            fill_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_addr_q <= fill_addr_d;
            fill_line_q <= fill_line_d;
            fill_byte_q <= fill_byte_d;
        end
    end

    always_ff @(posedge CLK) begin
        req_addr_q <= req_addr_d;
    end

    assign miss_ready = (state_q == IDLE);
    assign wb_ready   = !wbuf_valid;
    assign busy       = (state_q != IDLE) || wbuf_valid;
    assign fill_addr  = fill_addr_q;
    assign fill_line  = fill_line_q;
    assign fill_byte  = fill_byte_q;

endmodule

// File: tb/tb_gt_line_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gt_line_fill_ctrl
//   Directed bench for gt_line_fill_ctrl with a fixed-latency memory model.
// ---------------------------------------------------------------------------
module tb_gt_line_fill_ctrl;
    import gt_mem_pkg::*;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LINE_BYTES  = 32;
    localparam int unsigned MEM_LATENCY = 4;

    logic                 CLK = 1'b0;
    logic                 CLEAR = 1'b0;
    logic                 miss_req = 1'b0;
    logic [ADDR_W-1:0]    miss_addr = '0;
    logic                 miss_ready;
    logic                 wb_valid = 1'b0;
    logic [ADDR_W-1:0]    wb_addr = '0;
    logic [LINE_BITS-1:0] wb_data = '0;
    logic                 wb_ready;
    logic                 mem_rd, mem_wr;
    logic [ADDR_W-1:0]    mem_addr;
    logic [LINE_BITS-1:0] mem_wdata;
    logic [LINE_BITS-1:0] mem_rdata = '1;
    logic                 fill_valid;
    logic [ADDR_W-1:0]    fill_addr;
    logic [LINE_BITS-1:0] fill_line;
    logic [7:0]           fill_byte;
    logic                 busy;

    gt_line_fill_ctrl #(
        .LINE_BYTES  (LINE_BYTES),
        .MEM_LATENCY (MEM_LATENCY),
        .ADDR_W      (ADDR_W)
    ) dut (
        .CLK        (CLK),
        .CLEAR      (CLEAR),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_line  (fill_line),
        .fill_byte  (fill_byte),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor / memory model state
    int                   rd_cd = -1;
    int                   rd_cnt, wr_cnt, fill_cnt;
    int                   rd_cyc, wr_cyc, fill_cyc;
    logic [ADDR_W-1:0]    last_rd_addr, last_wr_addr, last_fill_addr;
    logic [LINE_BITS-1:0] last_wr_data, last_fill_line;
    logic [7:0]           last_fill_byte;
    logic [LINE_BITS-1:0] rd_line = '0;

    always @(posedge CLK) cyc = cyc + 1;

    // Memory returns rd_line only in the cycle exactly MEM_LATENCY after the
    // mem_rd cycle; all-ones otherwise so early or late capture is visible.
    always @(negedge CLK) begin
        if (rd_cd > 0) rd_cd = rd_cd - 1;
        else if (rd_cd == 0) rd_cd = -1;
        if (mem_rd === 1'b1) begin
            rd_cd        = MEM_LATENCY;
            rd_cnt       = rd_cnt + 1;
            rd_cyc       = cyc;
            last_rd_addr = mem_addr;
        end
        mem_rdata = (rd_cd == 0) ? rd_line : '1;
        if (mem_wr === 1'b1) begin
            wr_cnt       = wr_cnt + 1;
            wr_cyc       = cyc;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
        end
        if (fill_valid === 1'b1) begin
            fill_cnt       = fill_cnt + 1;
            fill_cyc       = cyc;
            last_fill_addr = fill_addr;
            last_fill_line = fill_line;
            last_fill_byte = fill_byte;
        end
        if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
            n_checks = n_checks + 1;
            if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
                n_fail = n_fail + 1;
                $display("FAIL rd_wr_exclusive: mem_rd=%b mem_wr=%b at cycle %0d, required not both 1",
                         mem_rd, mem_wr, cyc);
            end
        end
    end

    function automatic logic [LINE_BITS-1:0] make_line(input logic [7:0] base);
        logic [LINE_BITS-1:0] l;
        for (int i = 0; i < 32; i++) l[8*i +: 8] = base + 8'(i);
        return l;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        rd_cnt   = 0;
        wr_cnt   = 0;
        fill_cnt = 0;
        rd_cyc   = 0;
        wr_cyc   = 0;
        fill_cyc = 0;
    endtask

    task automatic test_reset();
        CLEAR = 1'b1;
        tick();
        tick();
        @(negedge CLK);
        n_checks++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_miss_ready: got %b want 1", miss_ready); end
        n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready: got %b want 1", wb_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_strobes: got rd=%b wr=%b want 0 0", mem_rd, mem_wr); end
        n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (fill_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fill_valid: got %b want 0", fill_valid); end
        n_checks++; if (fill_addr !== '0 || fill_byte !== 8'h00) begin n_fail++; $display("FAIL reset_fill_regs: got addr=%h byte=%h want 0 0", fill_addr, fill_byte); end
        n_checks++; if (fill_line !== '0) begin n_fail++; $display("FAIL reset_fill_line: got %h want 0", fill_line); end
        CLEAR = 1'b0;
        tick();
    endtask

    task automatic test_basic_miss();
        int a;
        clear_mon();
        rd_line   = make_line(8'hA2);
        miss_req  = 1'b1;
        miss_addr = 32'h0000_1045;
        @(negedge CLK);
        n_checks++; if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL basic_miss_ready: got %b want 1", miss_ready); end
        tick();
        a = cyc;
        miss_req  = 1'b0;
        miss_addr = '0;
        @(negedge CLK);
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_1040) begin n_fail++; $display("FAIL basic_mem_rd: got rd=%b addr=%h want 1 00001040", mem_rd, mem_addr); end
        n_checks++; if (miss_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy_ready: got miss_ready=%b want 0", miss_ready); end
        repeat (10) tick();
        n_checks++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL basic_rd_count: got %0d want 1", rd_cnt); end
        n_checks++; if (fill_cnt !== 1) begin n_fail++; $display("FAIL basic_fill_count: got %0d want 1", fill_cnt); end
        n_checks++; if (fill_cyc + 1 - a !== 6) begin n_fail++; $display("FAIL basic_fill_latency: got %0d want 6", fill_cyc + 1 - a); end
        n_checks++; if (last_fill_addr !== 32'h0000_1040) begin n_fail++; $display("FAIL basic_fill_addr: got %h want 00001040", last_fill_addr); end
        n_checks++; if (last_fill_byte !== 8'hA7) begin n_fail++; $display("FAIL basic_fill_byte: got %h want a7", last_fill_byte); end
        n_checks++; if (last_fill_line !== rd_line) begin n_fail++; $display("FAIL basic_fill_line: got %h want %h", last_fill_line, rd_line); end
        n_checks++; if (fill_byte !== 8'hA7 || fill_addr !== 32'h0000_1040) begin n_fail++; $display("FAIL basic_fill_hold: got byte=%h addr=%h want a7 00001040", fill_byte, fill_addr); end
        n_checks++; if (wr_cnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got wr=%0d busy=%b want 0 0", wr_cnt, busy); end
    endtask

    task automatic test_wb_drain();
        logic [LINE_BITS-1:0] d;
        clear_mon();
        d        = make_line(8'h10);
        wb_valid = 1'b1;
        wb_addr  = 32'h0000_2010;
        wb_data  = d;
        @(negedge CLK);
        n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL drain_wb_ready_pre: got %b want 1", wb_ready); end
        tick();
        wb_valid = 1'b0;
        @(negedge CLK);
        n_checks++; if (wb_ready !== 1'b0 || busy !== 1'b1 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL drain_held: got ready=%b busy=%b wr=%b want 0 1 0", wb_ready, busy, mem_wr); end
        tick();
        @(negedge CLK);
        n_checks++; if (mem_wr !== 1'b1 || mem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL drain_mem_wr: got wr=%b addr=%h want 1 00002000", mem_wr, mem_addr); end
        n_checks++; if (mem_wdata !== d) begin n_fail++; $display("FAIL drain_wdata: got %h want %h", mem_wdata, d); end
        tick();
        @(negedge CLK);
        n_checks++; if (wb_ready !== 1'b1 || busy !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL drain_after: got ready=%b busy=%b wr=%b want 1 0 0", wb_ready, busy, mem_wr); end
        n_checks++; if (wr_cnt !== 1 || rd_cnt !== 0) begin n_fail++; $display("FAIL drain_counts: got wr=%0d rd=%0d want 1 0", wr_cnt, rd_cnt); end
        tick();
    endtask

    task automatic test_forward();
        logic [LINE_BITS-1:0] d;
        logic [7:0]           exp_b;
        clear_mon();
        d        = make_line(8'h40);
        exp_b    = d[255:248];
        wb_valid = 1'b1;
        wb_addr  = 32'h0000_3000;
        wb_data  = d;
        tick();
        wb_valid  = 1'b0;
        miss_req  = 1'b1;
        miss_addr = 32'h0000_301F;
        @(negedge CLK);
        n_checks++; if (miss_ready !== 1'b1 || wb_ready !== 1'b0) begin n_fail++; $display("FAIL fwd_pre: got miss_ready=%b wb_ready=%b want 1 0", miss_ready, wb_ready); end
        tick();
        miss_req = 1'b0;
        @(negedge CLK);
        n_checks++; if (fill_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_fill_valid: got %b want 1", fill_valid); end
        n_checks++; if (fill_line !== d) begin n_fail++; $display("FAIL fwd_fill_line: got %h want %h", fill_line, d); end
        n_checks++; if (fill_byte !== exp_b || fill_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL fwd_fill_byte: got byte=%h addr=%h want %h 00003000", fill_byte, fill_addr, exp_b); end
        repeat (6) tick();
        n_checks++; if (rd_cnt !== 0 || fill_cnt !== 1) begin n_fail++; $display("FAIL fwd_counts: got rd=%0d fill=%0d want 0 1", rd_cnt, fill_cnt); end
        n_checks++; if (wr_cnt !== 1 || last_wr_addr !== 32'h0000_3000 || last_wr_data !== d) begin n_fail++; $display("FAIL fwd_drain: got wr=%0d addr=%h want 1 00003000", wr_cnt, last_wr_addr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fwd_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_simul_same_line();
        logic [LINE_BITS-1:0] d;
        clear_mon();
        d         = make_line(8'h60);
        wb_valid  = 1'b1;
        wb_addr   = 32'h0000_4000;
        wb_data   = d;
        miss_req  = 1'b1;
        miss_addr = 32'h0000_4003;
        tick();
        wb_valid = 1'b0;
        miss_req = 1'b0;
        @(negedge CLK);
        n_checks++; if (fill_valid !== 1'b1 || fill_byte !== 8'h63) begin n_fail++; $display("FAIL simul_fill: got valid=%b byte=%h want 1 63", fill_valid, fill_byte); end
        n_checks++; if (fill_line !== d || mem_rd !== 1'b0) begin n_fail++; $display("FAIL simul_line: got rd=%b line=%h want 0 %h", mem_rd, fill_line, d); end
        repeat (5) tick();
        n_checks++; if (wr_cnt !== 1 || last_wr_addr !== 32'h0000_4000 || rd_cnt !== 0) begin n_fail++; $display("FAIL simul_drain: got wr=%0d addr=%h rd=%0d want 1 00004000 0", wr_cnt, last_wr_addr, rd_cnt); end
    endtask

    task automatic test_bypass();
        logic [LINE_BITS-1:0] d;
        clear_mon();
        rd_line   = make_line(8'h80);
        d         = make_line(8'h20);
        wb_valid  = 1'b1;
        wb_addr   = 32'h0000_5000;
        wb_data   = d;
        miss_req  = 1'b1;
        miss_addr = 32'h0000_6000;
        tick();
        wb_valid = 1'b0;
        miss_req = 1'b0;
        @(negedge CLK);
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_6000 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL bypass_rd_first: got rd=%b wr=%b addr=%h want 1 0 00006000", mem_rd, mem_wr, mem_addr); end
        repeat (12) tick();
        n_checks++; if (rd_cnt !== 1 || fill_cnt !== 1 || last_fill_byte !== 8'h80) begin n_fail++; $display("FAIL bypass_fill: got rd=%0d fill=%0d byte=%h want 1 1 80", rd_cnt, fill_cnt, last_fill_byte); end
        n_checks++; if (wr_cnt !== 1 || last_wr_addr !== 32'h0000_5000 || last_wr_data !== d) begin n_fail++; $display("FAIL bypass_wr: got wr=%0d addr=%h want 1 00005000", wr_cnt, last_wr_addr); end
        n_checks++; if (!(wr_cyc > fill_cyc)) begin n_fail++; $display("FAIL bypass_order: got wr_cyc=%0d fill_cyc=%0d want wr after fill", wr_cyc, fill_cyc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bypass_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_read();
        int a;
        clear_mon();
        rd_line   = make_line(8'hE0);
        miss_req  = 1'b1;
        miss_addr = 32'h0000_7000;
        tick();
        miss_req = 1'b0;
        tick();
        tick();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        @(negedge CLK);
        n_checks++; if (miss_ready !== 1'b1 || wb_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got miss_ready=%b wb_ready=%b busy=%b want 1 1 0", miss_ready, wb_ready, busy); end
        n_checks++; if (fill_addr !== '0 || fill_byte !== 8'h00) begin n_fail++; $display("FAIL midrst_fill_cleared: got addr=%h byte=%h want 0 0", fill_addr, fill_byte); end
        repeat (8) tick();
        n_checks++; if (fill_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_fill: got %0d fills want 0", fill_cnt); end

        clear_mon();
        rd_line   = make_line(8'hC0);
        miss_req  = 1'b1;
        miss_addr = 32'h0000_8008;
        tick();
        a = cyc;
        miss_req = 1'b0;
        repeat (10) tick();
        n_checks++; if (fill_cnt !== 1 || fill_cyc + 1 - a !== 6) begin n_fail++; $display("FAIL midrst_next_fill: got fills=%0d latency=%0d want 1 6", fill_cnt, fill_cyc + 1 - a); end
        n_checks++; if (last_fill_byte !== 8'hC8 || last_fill_addr !== 32'h0000_8000) begin n_fail++; $display("FAIL midrst_next_data: got byte=%h addr=%h want c8 00008000", last_fill_byte, last_fill_addr); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic_miss();
        test_wb_drain();
        test_forward();
        test_simul_same_line();
        test_bypass();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

endmodule
